// File: rtl/xintf_divisor_capture.sv
// -----------------------------------------------------------------------------
// xintf_divisor_capture
//
// Upstream stage of the clock-divisor master. DSP XINTF writes arrive on pins
// that are asynchronous to clk. They are synchronised here, and each write is
// committed only once its strobe has been seen to complete. The low and high
// 16-bit divisor words are paired into one 32-bit divisor, and every
// successful pair produces one divisor_update pulse.
//
// Every committed write is also presented to other consumers on
// wr_strobe/wr_addr/wr_data.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   nCS            in   DSP chip select, active low, asynchronous to clk
//   nWR            in   DSP write strobe, active low, asynchronous to clk
//   address[14:0]  in   DSP address bus
//   data_in[15:0]  in   DSP data bus (write direction)
//   wr_strobe      out  one-cycle pulse per completed DSP write
//   wr_addr[14:0]  out  address of the last completed write
//   wr_data[15:0]  out  data of the last completed write
//   divisor[31:0]  out  current divisor {hi, lo}
//   divisor_update out  one-cycle pulse when the divisor is (re)loaded
//   pair_timeout   out  one-cycle pulse when a half pair is abandoned
//   pair_error     out  one-cycle pulse when a complete pair of 0 is rejected
// -----------------------------------------------------------------------------
module xintf_divisor_capture #(
   // Only bits [13:0] of the two word addresses are decoded.
   parameter logic [14:0] ADDR_LO     = 15'h400A,
   parameter logic [14:0] ADDR_HI     = 15'h400B,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 1024,
   parameter logic [31:0] DIV_RESET   = 32'd187500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nCS,
   input  logic        nWR,
   input  logic [14:0] address,
   input  logic [15:0] data_in,
   output logic        wr_strobe,
   output logic [14:0] wr_addr,
   output logic [15:0] wr_data,
   output logic [31:0] divisor,
   output logic        divisor_update,
   output logic        pair_timeout,
   output logic        pair_error
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

   // --------------------------------------------------------------------------
   // Synchronisers and aligned address/data delay line
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] ncs_sync_q;
   logic [SYNC_STAGES-1:0] nwr_sync_q;
   // Marks when the synchroniser holds real pin samples rather than reset values.
   logic [SYNC_STAGES-1:0] fill_q;
   logic [14:0]            addr_dly_q [SYNC_STAGES];
   logic [15:0]            data_dly_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ncs_sync_q <= '1;
         nwr_sync_q <= '1;
         fill_q     <= '0;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            addr_dly_q[i] <= '0;
            data_dly_q[i] <= '0;
         end
      end else begin
         ncs_sync_q    <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
         nwr_sync_q    <= {nwr_sync_q[SYNC_STAGES-2:0], nWR};
         fill_q        <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         addr_dly_q[0] <= address;
         data_dly_q[0] <= data_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            addr_dly_q[i] <= addr_dly_q[i-1];
            data_dly_q[i] <= data_dly_q[i-1];
         end
      end
   end

   logic        ncs_s;
   logic        nwr_s;
   logic        pipe_valid;
   logic        wr_act;
   logic [14:0] addr_al;
   logic [15:0] data_al;

   assign ncs_s      = ncs_sync_q[SYNC_STAGES-1];
   assign nwr_s      = nwr_sync_q[SYNC_STAGES-1];
   assign pipe_valid = fill_q[SYNC_STAGES-1];
   assign wr_act     = ~ncs_s & ~nwr_s;
   assign addr_al    = addr_dly_q[SYNC_STAGES-1];
   assign data_al    = data_dly_q[SYNC_STAGES-1];

   // --------------------------------------------------------------------------
   // Write capture: arm on leading edge, commit on trailing edge
   // --------------------------------------------------------------------------
   logic        act_q, act_d;
   logic        armed_q, armed_d;
   logic [14:0] sh_addr_q, sh_addr_d;
   logic [15:0] sh_data_q, sh_data_d;
   logic        wr_strobe_q, wr_strobe_d;
   logic [14:0] wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        wr_rise;
   logic        wr_fall;

   always_comb begin
      // act_q reads as "active" until real samples arrive, so a write already
      // in progress at reset release never shows a leading edge.
      wr_rise     = pipe_valid & wr_act & ~act_q;
      wr_fall     = armed_q & ~wr_act;
      act_d       = pipe_valid ? wr_act : 1'b1;
      armed_d     = armed_q;
      sh_addr_d   = sh_addr_q;
      sh_data_d   = sh_data_q;
      wr_strobe_d = wr_fall;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      if (wr_rise) begin
         armed_d = 1'b1;
      end else if (wr_fall) begin
         armed_d = 1'b0;
      end

      // Track the bus for the whole active phase; the last sample wins.
      if (wr_act && (armed_q || wr_rise)) begin
         sh_addr_d = addr_al;
         sh_data_d = data_al;
      end

      if (wr_fall) begin
         wr_addr_d = sh_addr_q;
         wr_data_d = sh_data_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q       <= 1'b1;
         armed_q     <= 1'b0;
         sh_addr_q   <= '0;
         sh_data_q   <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         act_q       <= act_d;
         armed_q     <= armed_d;
         sh_addr_q   <= sh_addr_d;
         sh_data_q   <= sh_data_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // --------------------------------------------------------------------------
   // Divisor pair FSM
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      StIdle,
      StHaveLo,
      StHaveHi
   } pair_state_e;

   pair_state_e state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0]   lo_sh_q, lo_sh_d;
   logic [15:0]   hi_sh_q, hi_sh_d;
   logic [31:0]   div_q, div_d;
   logic          upd_q, upd_d;
   logic          err_q, err_d;
   logic          to_q, to_d;
   logic          is_lo;
   logic          is_hi;
   logic          pair_done;
   logic [31:0]   cand;

   assign is_lo = wr_strobe_q && (wr_addr_q[13:0] == ADDR_LO[13:0]);
   assign is_hi = wr_strobe_q && (wr_addr_q[13:0] == ADDR_HI[13:0]);

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      lo_sh_d   = lo_sh_q;
      hi_sh_d   = hi_sh_q;
      div_d     = div_q;
      upd_d     = 1'b0;
      err_d     = 1'b0;
      to_d      = 1'b0;
      pair_done = 1'b0;
      cand      = '0;

      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (is_lo) begin
               lo_sh_d = wr_data_q;
               state_d = StHaveLo;
            end else if (is_hi) begin
               hi_sh_d = wr_data_q;
               state_d = StHaveHi;
            end
         end

         // A qualifying strobe is checked before the timer so it wins a tie.
         StHaveLo: begin
            if (is_lo) begin
               lo_sh_d = wr_data_q;
               timer_d = '0;
            end else if (is_hi) begin
               pair_done = 1'b1;
               cand      = {wr_data_q, lo_sh_q};
            end else if (timer_q == TimerLast) begin
               to_d    = 1'b1;
               state_d = StIdle;
               timer_d = '0;
               lo_sh_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         StHaveHi: begin
            if (is_hi) begin
               hi_sh_d = wr_data_q;
               timer_d = '0;
            end else if (is_lo) begin
               pair_done = 1'b1;
               cand      = {hi_sh_q, wr_data_q};
            end else if (timer_q == TimerLast) begin
               to_d    = 1'b1;
               state_d = StIdle;
               timer_d = '0;
               hi_sh_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase

      if (pair_done) begin
         state_d = StIdle;
         timer_d = '0;
         lo_sh_d = '0;
         hi_sh_d = '0;
         // A zero divisor would stall the downstream divider, so it is refused.
         if (cand != '0) begin
            div_d = cand;
            upd_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         timer_q <= '0;
         lo_sh_q <= '0;
         hi_sh_q <= '0;
         div_q   <= DIV_RESET;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         lo_sh_q <= lo_sh_d;
         hi_sh_q <= hi_sh_d;
         div_q   <= div_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   assign wr_strobe      = wr_strobe_q;
   assign wr_addr        = wr_addr_q;
   assign wr_data        = wr_data_q;
   assign divisor        = div_q;
   assign divisor_update = upd_q;
   assign pair_timeout   = to_q;
   assign pair_error     = err_q;

endmodule
